// File: rtl/rv_pkg.sv
// Shared constants for the RV front-end blocks.
package rv_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          INSTR_ALIGN      = 2;
   localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} pairs with flush; head is read combinationally.
module fetch_fifo
   import rv_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         push_pc,
   input  logic [WIDTH-1:0]         push_instr,
   output logic [WIDTH-1:0]         head_pc,
   output logic [WIDTH-1:0]         head_instr,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_pc    [DEPTH];
   logic [WIDTH-1:0] mem_instr [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head_pc    = mem_pc[rd_ptr];
   assign head_instr = mem_instr[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_pc[wr_ptr]    <= push_pc;
         mem_instr[wr_ptr] <= push_instr;
      end
   end

endmodule

// File: rtl/rv_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, pairs
// responses with their address and buffers them for decode; handles redirects.
module rv_fetch_stage
   import rv_pkg::*;
#(
   parameter int               WIDTH    = XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
   parameter int               DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   output logic [WIDTH-1:0] imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   input  logic [WIDTH-1:0] imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_instr,
   input  logic             out_ready
);

   localparam int CW = $clog2(DEPTH) + 2;

   logic [WIDTH-1:0]       pc;
   logic [CW-1:0]          inflight, drop, occupancy;
   logic [$clog2(DEPTH):0] out_count, aq_count;
   logic                   out_empty, out_full, aq_empty, aq_full;
   logic [WIDTH-1:0]       head_pc, head_instr, aq_pc, aq_instr;
   logic                   vld_p1, pop, accept, rsp_ok, rsp_keep;
   logic                   unused_sig;

   // Issue: credit from a same-cycle output transfer lets fetch run back-to-back.
   assign vld_p1         = ~rst & ~out_empty;
   assign pop            = vld_p1 & out_ready;
   assign occupancy      = inflight + CW'(out_count) - CW'(pop);
   assign imem_req_valid = ~rst & ~redirect_valid & (occupancy < CW'(DEPTH));
   assign imem_req_addr  = {pc[WIDTH-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
   assign accept         = imem_req_valid & imem_req_ready;

   // A response with nothing outstanding is ignored rather than corrupting the counters.
   assign rsp_ok   = imem_rsp_valid & (inflight != '0);
   assign rsp_keep = rsp_ok & (drop == '0) & ~redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else if (redirect_valid) begin
         pc       <= {redirect_pc[WIDTH-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
         inflight <= inflight - CW'(rsp_ok);
         drop     <= inflight - CW'(rsp_ok);
      end else begin
         if (accept) pc <= imem_req_addr + WIDTH'(4);
         inflight <= inflight + CW'(accept) - CW'(rsp_ok);
         if (rsp_ok && drop != '0) drop <= drop - CW'(1);
      end
   end

   // Address queue tags responses still owed to the current stream.
   fetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_addr_q (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .pop        (rsp_keep),
      .flush      (redirect_valid),
      .push_pc    (imem_req_addr),
      .push_instr ('0),
      .head_pc    (aq_pc),
      .head_instr (aq_instr),
      .full       (aq_full),
      .empty      (aq_empty),
      .count      (aq_count)
   );

   // Stage p1: registered {pc, instr} pairs presented to decode.
   fetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_q (
      .clk        (clk),
      .rst        (rst),
      .push       (rsp_keep),
      .pop        (pop & ~redirect_valid),
      .flush      (redirect_valid),
      .push_pc    (aq_pc),
      .push_instr (imem_rsp_data),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .full       (out_full),
      .empty      (out_empty),
      .count      (out_count)
   );

   assign out_valid = vld_p1;
   assign out_pc    = rst ? '0 : head_pc;
   assign out_instr = rst ? '0 : head_instr;

   assign unused_sig = ^{redirect_pc[INSTR_ALIGN-1:0], aq_instr, aq_full, aq_empty,
                         aq_count, out_full};

   assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (inflight != '0));

endmodule
